// File: rtl/rtc_bus_pkg.sv
// Shared definitions for the RTC multiplexed address/data bus sequencer.
// Contents: state encoding, default timing constants, rw encoding, the
// per-state control-pin decode and a small max helper for parameter math.
package rtc_bus_pkg;

    localparam int unsigned STATE_W = 4;

    // Nine bus-cycle states; the remaining 4-bit codes are illegal
    typedef enum logic [STATE_W-1:0] {
        ST_IDLE        = 4'd0,
        ST_ADDR_SETUP  = 4'd1,
        ST_ADDR_STROBE = 4'd2,
        ST_ADDR_HOLD   = 4'd3,
        ST_GAP         = 4'd4,
        ST_DATA_SETUP  = 4'd5,
        ST_DATA_STROBE = 4'd6,
        ST_DATA_HOLD   = 4'd7,
        ST_RECOVER     = 4'd8
    } state_t;

    localparam int unsigned DEF_DATA_W    = 8;
    localparam int unsigned DEF_T_SETUP   = 3;
    localparam int unsigned DEF_T_PULSE   = 15;
    localparam int unsigned DEF_T_HOLD    = 3;
    localparam int unsigned DEF_T_GAP     = 15;
    localparam int unsigned DEF_T_RECOVER = 70;

    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ  = 1'b1;

    // Control pins for one state; drive_data selects wdata over addr on the pads
    typedef struct packed {
        logic a_d;
        logic cs;
        logic wr;
        logic rd;
        logic oe;
        logic drive_data;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '{a_d: 1'b1, cs: 1'b1, wr: 1'b1, rd: 1'b1,
                                    oe: 1'b0, drive_data: 1'b0};

    // Pin decode from state and latched direction only
    function automatic ctrl_t decode_ctrl(input state_t st, input logic rw);
        ctrl_t c;
        c = CTRL_IDLE;
        case (st)
            ST_ADDR_SETUP, ST_ADDR_HOLD: begin
                c.a_d = 1'b0;
                c.oe  = 1'b1;
            end
            ST_ADDR_STROBE: begin
                c.a_d = 1'b0;
                c.oe  = 1'b1;
                c.cs  = 1'b0;
                c.wr  = 1'b0;
            end
            ST_DATA_SETUP, ST_DATA_HOLD: begin
                c.oe         = (rw == RW_WRITE);
                c.drive_data = (rw == RW_WRITE);
            end
            ST_DATA_STROBE: begin
                c.cs = 1'b0;
                if (rw == RW_WRITE) begin
                    c.wr         = 1'b0;
                    c.oe         = 1'b1;
                    c.drive_data = 1'b1;
                end else begin
                    c.rd = 1'b0;
                end
            end
            default: c = CTRL_IDLE;
        endcase
        return c;
    endfunction

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/rtc_phase_timer.sv
// Phase length timer shared by all sequencer phases.
// Ports: clk, reset (sync, active high); load restarts the count at 0 with a
// new terminal value limit; term_c flags the last cycle of the running phase;
// term_next_c flags that the following cycle will be the last one.
module rtc_phase_timer #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] limit,
    output logic             term_c,
    output logic             term_next_c
);

    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] limit_q;

    // Count up to the terminal value and hold there; never wraps inside a phase
    always_ff @(posedge clk) begin
        if (reset) begin
            count   <= '0;
            limit_q <= '0;
        end else if (load) begin
            count   <= '0;
            limit_q <= limit;
        end else if (count != limit_q) begin
            count <= count + CNT_W'(1);
        end
    end

    assign term_c = (count == limit_q);

    // Look-ahead lets the owner register pulses that land on the last cycle
    assign term_next_c = load ? (limit == '0)
                              : ((count != limit_q) && ((count + CNT_W'(1)) == limit_q));

endmodule

// File: rtl/rtc_bus_sequencer.sv
// Bus-cycle sequencer for the multiplexed address/data RTC interface.
// Each request runs an address phase then a write or read data phase, with all
// phase lengths set by parameters and timed by one shared phase timer.
// Ports: Clock_in/Reset (sync, active high); start/rw/addr/wdata request and
// busy/done/rdata/rdata_valid status toward the control FSM; A_D/CS/WR/RD
// strobes and bus_out/bus_oe/bus_in toward the tri-state pads.
module rtc_bus_sequencer
    import rtc_bus_pkg::*;
#(
    parameter int unsigned DATA_W    = DEF_DATA_W,
    parameter int unsigned T_SETUP   = DEF_T_SETUP,
    parameter int unsigned T_PULSE   = DEF_T_PULSE,
    parameter int unsigned T_HOLD    = DEF_T_HOLD,
    parameter int unsigned T_GAP     = DEF_T_GAP,
    parameter int unsigned T_RECOVER = DEF_T_RECOVER
) (
    input  logic              Clock_in,
    input  logic              Reset,
    input  logic              start,
    input  logic              rw,
    input  logic [DATA_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rdata,
    output logic              rdata_valid,
    output logic              A_D,
    output logic              CS,
    output logic              WR,
    output logic              RD,
    output logic [DATA_W-1:0] bus_out,
    output logic              bus_oe,
    input  logic [DATA_W-1:0] bus_in
);

    localparam int unsigned T_MAX = max_u(max_u(max_u(T_SETUP, T_PULSE), max_u(T_HOLD, T_GAP)),
                                          T_RECOVER);
    localparam int unsigned CNT_W = $clog2(T_MAX) + 1;

    state_t            state_reg;
    state_t            state_nxt;
    logic              rw_q;
    logic              rw_nxt;
    logic [DATA_W-1:0] addr_q;
    logic [DATA_W-1:0] addr_nxt;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] wdata_nxt;
    logic              accept_c;
    logic              load_c;
    logic              term_c;
    logic              term_next_c;
    logic              last_recover_c;
    logic [CNT_W-1:0]  limit_c;
    ctrl_t             ctrl_nxt;

    // Terminal count (length - 1) for each timed phase
    function automatic logic [CNT_W-1:0] phase_limit(input state_t st);
        case (st)
            ST_ADDR_SETUP, ST_DATA_SETUP:   return CNT_W'(T_SETUP - 1);
            ST_ADDR_STROBE, ST_DATA_STROBE: return CNT_W'(T_PULSE - 1);
            ST_ADDR_HOLD, ST_DATA_HOLD:     return CNT_W'(T_HOLD - 1);
            ST_GAP:                         return CNT_W'(T_GAP - 1);
            ST_RECOVER:                     return CNT_W'(T_RECOVER - 1);
            default:                        return '0;
        endcase
    endfunction

    assign accept_c = (state_reg == ST_IDLE) && start;

    // Next-state: every timed phase advances on its terminal count
    always_comb begin
        state_nxt = state_reg;
        case (state_reg)
            ST_IDLE:        if (start)  state_nxt = ST_ADDR_SETUP;
            ST_ADDR_SETUP:  if (term_c) state_nxt = ST_ADDR_STROBE;
            ST_ADDR_STROBE: if (term_c) state_nxt = ST_ADDR_HOLD;
            ST_ADDR_HOLD:   if (term_c) state_nxt = ST_GAP;
            ST_GAP:         if (term_c) state_nxt = ST_DATA_SETUP;
            ST_DATA_SETUP:  if (term_c) state_nxt = ST_DATA_STROBE;
            ST_DATA_STROBE: if (term_c) state_nxt = ST_DATA_HOLD;
            ST_DATA_HOLD:   if (term_c) state_nxt = ST_RECOVER;
            ST_RECOVER:     if (term_c) state_nxt = ST_IDLE;
            default:                    state_nxt = ST_IDLE;
        endcase
    end

    // Request fields are captured only when a request is accepted
    always_comb begin
        rw_nxt    = accept_c ? rw    : rw_q;
        addr_nxt  = accept_c ? addr  : addr_q;
        wdata_nxt = accept_c ? wdata : wdata_q;
    end

    // Timer restarts on every state change and is held at 0 while idle
    assign load_c  = (state_nxt != state_reg) || (state_nxt == ST_IDLE);
    assign limit_c = phase_limit(state_nxt);

    rtc_phase_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk         (Clock_in),
        .reset       (Reset),
        .load        (load_c),
        .limit       (limit_c),
        .term_c      (term_c),
        .term_next_c (term_next_c)
    );

    // Outputs are registered from the decode of the upcoming state so they
    // line up with state_reg and never toggle within a state
    assign ctrl_nxt       = decode_ctrl(state_nxt, rw_nxt);
    assign last_recover_c = (state_nxt == ST_RECOVER) && term_next_c;

    always_ff @(posedge Clock_in) begin
        if (Reset) begin
            state_reg   <= ST_IDLE;
            rw_q        <= RW_WRITE;
            addr_q      <= '0;
            wdata_q     <= '0;
            A_D         <= 1'b1;
            CS          <= 1'b1;
            WR          <= 1'b1;
            RD          <= 1'b1;
            bus_oe      <= 1'b0;
            bus_out     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            rdata_valid <= 1'b0;
            rdata       <= '0;
        end else begin
            state_reg   <= state_nxt;
            rw_q        <= rw_nxt;
            addr_q      <= addr_nxt;
            wdata_q     <= wdata_nxt;
            A_D         <= ctrl_nxt.a_d;
            CS          <= ctrl_nxt.cs;
            WR          <= ctrl_nxt.wr;
            RD          <= ctrl_nxt.rd;
            bus_oe      <= ctrl_nxt.oe;
            bus_out     <= ctrl_nxt.oe ? (ctrl_nxt.drive_data ? wdata_nxt : addr_nxt) : '0;
            busy        <= (state_nxt != ST_IDLE);
            done        <= last_recover_c;
            rdata_valid <= last_recover_c && (rw_nxt == RW_READ);
            // Sample the pads on the last strobe cycle, while RD is still low
            if ((state_reg == ST_DATA_STROBE) && term_c && (rw_q == RW_READ)) begin
                rdata <= bus_in;
            end
        end
    end

endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// Self-checking bench for rtc_bus_sequencer: a default-parameter instance and
// a minimum-timing 16-bit instance, compared cycle by cycle against a phase
// table model built from the bus-cycle description.
module tb_rtc_bus_sequencer;

    typedef int lens_t [8];

    // Phase lengths in order: addr setup/strobe/hold, gap, data setup/strobe/hold, recover
    lens_t lens_a = '{3, 15, 3, 15, 3, 15, 3, 70};
    lens_t lens_m = '{1, 1, 1, 1, 1, 1, 1, 1};

    int checks = 0;
    int errors = 0;
    int sum_a;
    int sum_m;

    logic clk = 1'b0;
    logic reset;

    logic        start, rw, busy, done, rdata_valid, a_d, cs, wr, rd, bus_oe;
    logic [7:0]  addr, wdata, rdata, bus_out, bus_in;
    logic [7:0]  rdata_model;

    logic        start_m, rw_m, busy_m, done_m, rdata_valid_m, a_d_m, cs_m, wr_m, rd_m, bus_oe_m;
    logic [15:0] addr_m, wdata_m, rdata_m, bus_out_m, bus_in_m;

    always #5 clk = ~clk;

    rtc_bus_sequencer dut (
        .Clock_in (clk), .Reset (reset), .start (start), .rw (rw),
        .addr (addr), .wdata (wdata), .busy (busy), .done (done),
        .rdata (rdata), .rdata_valid (rdata_valid), .A_D (a_d), .CS (cs),
        .WR (wr), .RD (rd), .bus_out (bus_out), .bus_oe (bus_oe), .bus_in (bus_in)
    );

    rtc_bus_sequencer #(
        .DATA_W (16), .T_SETUP (1), .T_PULSE (1), .T_HOLD (1), .T_GAP (1), .T_RECOVER (1)
    ) dut_m (
        .Clock_in (clk), .Reset (reset), .start (start_m), .rw (rw_m),
        .addr (addr_m), .wdata (wdata_m), .busy (busy_m), .done (done_m),
        .rdata (rdata_m), .rdata_valid (rdata_valid_m), .A_D (a_d_m), .CS (cs_m),
        .WR (wr_m), .RD (rd_m), .bus_out (bus_out_m), .bus_oe (bus_oe_m), .bus_in (bus_in_m)
    );

    // Phase index (0..7) of cycle k counted from 1 after the accepting edge; 8 = idle
    function automatic int phase_of(input lens_t lens, input int k);
        int acc;
        acc = 0;
        for (int i = 0; i < 8; i++) begin
            acc += lens[i];
            if (k <= acc) return i;
        end
        return 8;
    endfunction

    function automatic int total_of(input lens_t lens, input int n);
        int acc;
        acc = 0;
        for (int i = 0; i < n; i++) acc += lens[i];
        return acc;
    endfunction

    // Expected {A_D, CS, WR, RD, bus_oe, busy, done, rdata_valid} for cycle k
    function automatic logic [7:0] model_ctrl(input lens_t lens, input int k, input logic rwv);
        int   p;
        logic a, c, w, r, oe, bz, dn;
        p = phase_of(lens, k);
        {a, c, w, r, oe} = 5'b11110;
        case (p)
            0, 2: begin a = 1'b0; oe = 1'b1; end
            1:    begin a = 1'b0; c = 1'b0; w = 1'b0; oe = 1'b1; end
            4, 6: oe = ~rwv;
            5: begin
                c  = 1'b0;
                oe = ~rwv;
                if (rwv) r = 1'b0;
                else     w = 1'b0;
            end
            default: ;
        endcase
        bz = (p < 8);
        dn = (k == total_of(lens, 8));
        return {a, c, w, r, oe, bz, dn, dn & rwv};
    endfunction

    task automatic test_reset();
        checks++;
        if ({a_d, cs, wr, rd, bus_oe, busy, done, rdata_valid} !== 8'b1111_0000) begin
            errors++;
            $display("FAIL reset_ctrl got %b exp %b", {a_d, cs, wr, rd, bus_oe, busy, done, rdata_valid}, 8'b1111_0000);
        end
        checks++;
        if (bus_out !== 8'h00 || rdata !== 8'h00) begin
            errors++;
            $display("FAIL reset_data bus_out %h rdata %h exp 00 00", bus_out, rdata);
        end
        checks++;
        if ({a_d_m, cs_m, wr_m, rd_m, bus_oe_m, busy_m, done_m, rdata_valid_m} !== 8'b1111_0000) begin
            errors++;
            $display("FAIL reset_ctrl_min got %b exp %b", {a_d_m, cs_m, wr_m, rd_m, bus_oe_m, busy_m, done_m, rdata_valid_m}, 8'b1111_0000);
        end
        checks++;
        if (bus_out_m !== 16'h0 || rdata_m !== 16'h0) begin
            errors++;
            $display("FAIL reset_data_min bus_out %h rdata %h exp 0 0", bus_out_m, rdata_m);
        end
    endtask

    // One full transaction on the default instance, checked every cycle
    task automatic test_transaction(input logic rwv, input logic [7:0] a, input logic [7:0] d,
                                    input logic fix, input logic [7:0] fixv);
        logic [7:0] exp_v, got_v, exp_r, exp_bus;
        int         last_strobe, p;
        last_strobe = total_of(lens_a, 6);
        exp_r = rdata_model;
        start = 1'b1; rw = rwv; addr = a; wdata = d; bus_in = 8'($urandom);
        for (int k = 1; k <= sum_a + 1; k++) begin
            @(posedge clk); #1;
            if (k == 1) begin
                // Scramble the request inputs: the DUT must use its latched copy
                start = 1'b0; rw = 1'($urandom); addr = 8'($urandom); wdata = 8'($urandom);
            end
            p = phase_of(lens_a, k);
            exp_v = model_ctrl(lens_a, k, rwv);
            got_v = {a_d, cs, wr, rd, bus_oe, busy, done, rdata_valid};
            checks++;
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL txn_ctrl rw=%0b k=%0d got %b exp %b", rwv, k, got_v, exp_v);
            end
            if (exp_v[3]) begin
                exp_bus = (p < 3) ? a : d;
                checks++;
                if (bus_out !== exp_bus) begin
                    errors++;
                    $display("FAIL txn_bus_out rw=%0b k=%0d got %h exp %h", rwv, k, bus_out, exp_bus);
                end
            end
            if (k == sum_a) begin
                checks++;
                if (rdata !== exp_r) begin
                    errors++;
                    $display("FAIL txn_rdata rw=%0b got %h exp %h", rwv, rdata, exp_r);
                end
            end
            bus_in = (fix && p == 5) ? fixv : 8'($urandom);
            if (rwv && k == last_strobe) exp_r = bus_in;
        end
        rdata_model = exp_r;
    endtask

    task automatic test_reset_mid();
        int stop_k;
        stop_k = total_of(lens_a, 5) + 2;
        start = 1'b1; rw = 1'b0; addr = 8'($urandom); wdata = 8'($urandom);
        for (int k = 1; k <= stop_k; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        checks++;
        if (cs !== 1'b0 || wr !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_strobe cs %b wr %b exp 0 0", cs, wr);
        end
        reset = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({a_d, cs, wr, rd, bus_oe, busy, done, rdata_valid} !== 8'b1111_0000) begin
            errors++;
            $display("FAIL reset_mid_ctrl got %b exp %b", {a_d, cs, wr, rd, bus_oe, busy, done, rdata_valid}, 8'b1111_0000);
        end
        checks++;
        if (rdata !== 8'h00 || bus_out !== 8'h00) begin
            errors++;
            $display("FAIL reset_mid_data rdata %h bus_out %h exp 00 00", rdata, bus_out);
        end
        reset = 1'b0;
        rdata_model = 8'h00;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || cs !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_after busy %b cs %b exp 0 1", busy, cs);
        end
    endtask

    // start toggled at random while busy must not queue a second transaction
    task automatic test_ignore_start();
        int n_done, busy_bad;
        logic [7:0] a0;
        n_done = 0; busy_bad = 0;
        a0 = 8'($urandom);
        start = 1'b1; rw = 1'b0; addr = a0; wdata = 8'($urandom);
        for (int k = 1; k <= sum_a + 20; k++) begin
            @(posedge clk); #1;
            start = (k <= sum_a - 1) ? 1'($urandom) : 1'b0;
            addr  = 8'($urandom);
            if (done) n_done++;
            if (busy !== (k <= sum_a)) busy_bad++;
            if (k == 2) begin
                checks++;
                if (bus_out !== a0) begin
                    errors++;
                    $display("FAIL ignore_addr got %h exp %h", bus_out, a0);
                end
            end
        end
        checks++;
        if (n_done != 1) begin
            errors++;
            $display("FAIL ignore_done_count got %0d exp 1", n_done);
        end
        checks++;
        if (busy_bad != 0) begin
            errors++;
            $display("FAIL ignore_busy bad_cycles %0d exp 0", busy_bad);
        end
    endtask

    task automatic test_back_to_back();
        int done_q[$];
        int idle_q[$];
        logic [7:0] a0;
        a0 = 8'($urandom);
        start = 1'b1; rw = 1'($urandom); addr = a0; wdata = 8'($urandom);
        for (int k = 1; k <= 2 * sum_a + 2; k++) begin
            @(posedge clk); #1;
            if (done) done_q.push_back(k);
            if (!busy) idle_q.push_back(k);
            if (k == sum_a + 2) begin
                checks++;
                if (bus_out !== a0 || a_d !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_second_addr got %h a_d %b exp %h 0", bus_out, a_d, a0);
                end
            end
            if (k == 2 * sum_a + 2) start = 1'b0;
        end
        checks++;
        if (done_q.size() != 2 || done_q[0] != sum_a || done_q[1] != 2 * sum_a + 1) begin
            errors++;
            $display("FAIL b2b_done count %0d first %0d exp 2 at %0d and %0d",
                     done_q.size(), (done_q.size() > 0) ? done_q[0] : -1, sum_a, 2 * sum_a + 1);
        end
        checks++;
        if (idle_q.size() != 2 || idle_q[0] != sum_a + 1 || idle_q[1] != 2 * sum_a + 2) begin
            errors++;
            $display("FAIL b2b_idle count %0d first %0d exp 2 at %0d and %0d",
                     idle_q.size(), (idle_q.size() > 0) ? idle_q[0] : -1, sum_a + 1, 2 * sum_a + 2);
        end
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_stop busy %b exp 0", busy);
        end
    endtask

    // Minimum timing, 16-bit instance: one cycle per phase, done eight cycles after start
    task automatic test_min_params(input logic rwv);
        logic [7:0]  exp_v, got_v;
        logic [15:0] a, d, exp_r, exp_bus;
        int          p;
        a = 16'($urandom); d = 16'($urandom);
        exp_r = rdata_m;
        start_m = 1'b1; rw_m = rwv; addr_m = a; wdata_m = d; bus_in_m = 16'($urandom);
        for (int k = 1; k <= sum_m + 1; k++) begin
            @(posedge clk); #1;
            start_m = 1'b0; addr_m = 16'($urandom); wdata_m = 16'($urandom);
            p = phase_of(lens_m, k);
            exp_v = model_ctrl(lens_m, k, rwv);
            got_v = {a_d_m, cs_m, wr_m, rd_m, bus_oe_m, busy_m, done_m, rdata_valid_m};
            checks++;
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL min_ctrl rw=%0b k=%0d got %b exp %b", rwv, k, got_v, exp_v);
            end
            if (exp_v[3]) begin
                exp_bus = (p < 3) ? a : d;
                checks++;
                if (bus_out_m !== exp_bus) begin
                    errors++;
                    $display("FAIL min_bus_out rw=%0b k=%0d got %h exp %h", rwv, k, bus_out_m, exp_bus);
                end
            end
            if (k == sum_m) begin
                checks++;
                if (rdata_m !== exp_r) begin
                    errors++;
                    $display("FAIL min_rdata rw=%0b got %h exp %h", rwv, rdata_m, exp_r);
                end
            end
            bus_in_m = 16'($urandom);
            if (rwv && p == 5) exp_r = bus_in_m;
        end
    endtask

    initial begin
        sum_a = total_of(lens_a, 8);
        sum_m = total_of(lens_m, 8);
        rdata_model = 8'h00;
        reset = 1'b1;
        start = 1'b0; rw = 1'b0; addr = 8'h00; wdata = 8'h00; bus_in = 8'h00;
        start_m = 1'b0; rw_m = 1'b0; addr_m = 16'h0; wdata_m = 16'h0; bus_in_m = 16'h0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk); #1;

        test_reset();
        test_transaction(1'b0, 8'h21, 8'h5A, 1'b0, 8'h00);
        test_reset_mid();
        test_transaction(1'b1, 8'h22, 8'h00, 1'b1, 8'hC3);
        checks++;
        if (rdata !== 8'hC3) begin
            errors++;
            $display("FAIL read_c3 got %h exp c3", rdata);
        end
        for (int i = 0; i < 4; i++) begin
            test_transaction(1'($urandom), 8'($urandom), 8'($urandom), 1'b0, 8'h00);
        end
        test_ignore_start();
        test_back_to_back();
        test_min_params(1'b0);
        test_min_params(1'b1);
        test_min_params(1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
